dmem_responder: RTL

//  Data-memory responder for the pipelined MIPS core's data port: accepts one load/store per request
//  (byte enables, address, store data) and returns read data after a fixed latency, asserting stall

---
 rtl/dmem_pkg.sv | 7 +
 rtl/dmem_bank.sv | 23 ++
 rtl/dmem_responder.sv | 74 +++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared FSM state type and constants for the data-memory responder
package dmem_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  localparam int LAT_MAX = 15;
  localparam int CNT_W = 4;
  localparam logic [3:0] WEN_LOAD = 4'b0000;
endpackage

// File: rtl/dmem_bank.sv
// dmem_bank: word-addressed synchronous RAM, four byte-lane write enables, read-before-write
module dmem_bank import dmem_pkg::*; #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              zero,
  input  logic [3:0]        wen,
  input  logic [ADDR_W-1:0] idx,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);
  logic [31:0] mem [2**ADDR_W];
  // write each enabled byte lane on an access edge; contents are never reset
  always_ff @(posedge clk)
    for (int i = 0; i < 4; i++)
      if (en && wen[i]) mem[idx][8*i+:8] <= wdata[8*i+:8];
  // capture the old word (or zero for a rejected access); holds between accesses
  always_ff @(posedge clk or posedge rst)
    if (rst) rdata <= '0;
    else if (en) rdata <= zero ? '0 : mem[idx];
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: fixed-latency load/store responder with stall; DMEM_RANGE_CHECK_EN enables out-of-range flagging
module dmem_responder import dmem_pkg::*; #(
  parameter int ADDR_W = 10,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic [3:0]  wen,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        resp_valid,
  output logic        err
);
  state_t state, nextState;
  logic [CNT_W-1:0] cnt;
  logic [ADDR_W-1:0] idxQ, idxSel;
  logic [3:0] wenQ, wenSel;
  logic [31:0] wdataQ, wdataSel;
  logic oorNow, oorQ, oorSel, idle, access, unusedAddr;
`ifdef DMEM_RANGE_CHECK_EN
  assign oorNow = |addr[31:ADDR_W+2];
`else
  assign oorNow = 1'b0;
`endif
  assign unusedAddr = &{1'b0, addr[1:0], addr[31:ADDR_W+2]};
  assign idle = state == IDLE;
  // in IDLE the access may happen on the accept edge itself, so use the live request
  assign idxSel = idle ? addr[ADDR_W+1:2] : idxQ;
  assign wenSel = idle ? wen : wenQ;
  assign wdataSel = idle ? wdata : wdataQ;
  assign oorSel = idle ? oorNow : oorQ;
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= nextState;
  // next state and handshake outputs
  always_comb begin
    nextState = state == DONE ? IDLE
              : state == BUSY ? (cnt == CNT_W'(1) ? DONE : BUSY)
              : req ? (LATENCY == 1 ? DONE : BUSY) : IDLE;
    access = nextState == DONE && state != DONE && !rst;
    stall = req && state != DONE;
    resp_valid = state == DONE;
    err = resp_valid && oorQ;
  end
  // request latches and latency down-counter
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      idxQ <= '0;
      wenQ <= '0;
      wdataQ <= '0;
      oorQ <= 1'b0;
    end else if (idle && req) begin
      cnt <= CNT_W'(LATENCY - 1);
      idxQ <= addr[ADDR_W+1:2];
      wenQ <= wen;
      wdataQ <= wdata;
      oorQ <= oorNow;
    end else if (state == BUSY) cnt <= cnt - 1'b1;
  dmem_bank #(.ADDR_W(ADDR_W)) bank (
    .clk(clk),
    .rst(rst),
    .en(access),
    .zero(oorSel),
    .wen(oorSel ? WEN_LOAD : wenSel),
    .idx(idxSel),
    .wdata(wdataSel),
    .rdata(rdata)
  );
endmodule
